// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROR = 2'b11
    } shift_op_e;

    function automatic int popcount(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational mux level of the logarithmic shifter: shifts by DIST when sel is set.
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             sel,
    input  shift_op_e        op,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);

    // SRA fills from the operand's original sign, never from this level's MSB.
    always_comb begin
        result = data;
        if (sel) begin
            case (op)
                SLL:     result = data << DIST;
                SRL:     result = data >> DIST;
                SRA:     result = {{DIST{sign}}, data[WIDTH-1:DIST]};
                ROR:     result = {data[DIST-1:0], data[WIDTH-1:DIST]};
                default: result = data;
            endcase
        end
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined logarithmic shifter (SLL/SRL/SRA/ROR) with selectable register
// boundaries between mux levels and a stallable valid/ready handshake.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int             WIDTH     = 32,
    parameter int             SHW       = $clog2(WIDTH),
    parameter logic [SHW-1:0] REG_AFTER = SHW'(5'b00100),
    parameter int             TAG_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LATENCY = 1 + popcount(64'(REG_AFTER));

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   shamt;
        shift_op_e        op;
        logic             sign;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t             in_stage;
    stage_t             slot_d [LATENCY];
    stage_t             slot_p [LATENCY];
    logic [LATENCY-1:0] vld_p;
    logic [LATENCY-1:0] load;
    logic               unused_bits;

    assign in_stage = '{
        data:  in_data,
        shamt: in_shamt[SHW-1:0],
        op:    shift_op_e'(in_op),
        sign:  in_data[WIDTH-1],
        tag:   in_tag
    };

    // Mux levels, with a register slot after every level whose REG_AFTER bit is set
    for (genvar k = 0; k < SHW; k++) begin : g_lvl
        stage_t           src;
        stage_t           res;
        logic [WIDTH-1:0] shifted;

        if (k == 0) begin : g_src_in
            assign src = in_stage;
        end else begin : g_src_chain
            if (REG_AFTER[k-1]) begin : g_src_reg
                localparam int SLOT = popcount(64'(REG_AFTER) & ((64'd1 << k) - 64'd1)) - 1;
                assign src = slot_p[SLOT];
            end else begin : g_src_comb
                assign src = g_lvl[k-1].res;
            end
        end

        shift_level #(
            .WIDTH(WIDTH),
            .DIST (1 << k)
        ) u_level (
            .data  (src.data),
            .sel   (src.shamt[k]),
            .op    (src.op),
            .sign  (src.sign),
            .result(shifted)
        );

        always_comb begin
            res      = src;
            res.data = shifted;
        end

        if (REG_AFTER[k]) begin : g_slot
            localparam int SLOT = popcount(64'(REG_AFTER) & ((64'd1 << k) - 64'd1));
            assign slot_d[SLOT] = res;
        end
    end

    // Output slot is always present, fed by the last level or the last inner slot
    if (REG_AFTER[SHW-1]) begin : g_out_reg
        assign slot_d[LATENCY-1] = slot_p[LATENCY-2];
    end else begin : g_out_comb
        assign slot_d[LATENCY-1] = g_lvl[SHW-1].res;
    end

    // A slot loads when it is empty or its content moves on this cycle.
    always_comb begin
        logic ld;
        load = '0;
        ld   = out_ready || !vld_p[LATENCY-1];
        load[LATENCY-1] = ld;
        for (int i = LATENCY - 2; i >= 0; i--) begin
            ld      = !vld_p[i] || ld;
            load[i] = ld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            if (load[0]) begin
                vld_p[0] <= in_valid;
            end
            for (int i = 1; i < LATENCY; i++) begin
                if (load[i]) begin
                    vld_p[i] <= vld_p[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LATENCY; i++) begin
            if (load[i]) begin
                slot_p[i] <= slot_d[i];
            end
        end
    end

    assign in_ready  = load[0] && !rst;
    assign out_valid = vld_p[LATENCY-1];
    assign out_data  = slot_p[LATENCY-1].data;
    assign out_tag   = slot_p[LATENCY-1].tag;

    assign unused_bits = ^{in_shamt[WIDTH-1:SHW], slot_p[LATENCY-1].shamt,
                           slot_p[LATENCY-1].op, slot_p[LATENCY-1].sign};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe: three configurations run side by side
// against an arithmetic reference model.
module tb_shift_unit_pipe;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        bit          lat;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    int n_done      = 0;

    logic [63:0] dir_d [9] = '{64'h8000_0000, 64'h1, 64'hF000_0000, 64'h1, 64'hFFFF_FFFF,
                               64'hA5C3_0F96, 64'hA5C3_0F96, 64'hA5C3_0F96, 64'hA5C3_0F96};
    logic [63:0] dir_s [9] = '{64'd4, 64'd31, 64'd28, 64'd1, 64'h25,
                               64'h20, 64'h20, 64'h20, 64'h20};
    logic [1:0]  dir_o [9] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [4:0]  dir_t [9] = '{5'd3, 5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};

    // Reference: shift amount is shamt modulo the width; results masked to w bits.
    function automatic logic [63:0] model(input int w, input logic [63:0] d,
                                          input logic [63:0] sh, input logic [1:0] op);
        logic [63:0] mask, v;
        int s;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        v    = d & mask;
        s    = int'(sh % 64'(w));
        case (op)
            2'd0:    return (v << s) & mask;
            2'd1:    return v >> s;
            2'd2:    return v[w-1] ? ((v >> s) | (mask & ~(mask >> s))) : (v >> s);
            default: return ((v >> s) | (v << (w - s))) & mask;
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input int cfg, input string name, input logic [63:0] got,
                         input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL cfg%0d %s: got 0x%0h, want 0x%0h", cfg, name, got, want);
        end
    endtask

    for (genvar c = 0; c < 3; c++) begin : g_cfg
        localparam int W    = (c == 0) ? 32 : ((c == 1) ? 8 : 64);
        localparam int SW   = $clog2(W);
        localparam logic [SW-1:0] RA = (c == 0) ? SW'(4) : ((c == 1) ? SW'(0) : {SW{1'b1}});
        localparam int LAT  = (c == 0) ? 2 : ((c == 1) ? 1 : 7);
        localparam int NVEC = (c == 0) ? 4000 : 3000;

        logic         rst       = 1'b1;
        logic         in_valid  = 1'b0;
        logic         in_ready;
        logic [W-1:0] in_data   = '0;
        logic [W-1:0] in_shamt  = '0;
        logic [1:0]   in_op     = '0;
        logic [4:0]   in_tag    = '0;
        logic         out_valid;
        logic         out_ready = 1'b1;
        logic [W-1:0] out_data;
        logic [4:0]   out_tag;
        exp_t         q[$];
        bit           lat_mode  = 1'b0;
        bit           stop      = 1'b0;

        shift_unit_pipe #(
            .WIDTH    (W),
            .REG_AFTER(RA),
            .TAG_W    (5)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .in_data  (in_data),
            .in_shamt (in_shamt),
            .in_op    (in_op),
            .in_tag   (in_tag),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_data (out_data),
            .out_tag  (out_tag)
        );

        task automatic send(input logic [63:0] d, input logic [63:0] sh,
                            input logic [1:0] op, input logic [4:0] tag);
            exp_t e;
            bit   acc;
            int   n, cs;
            in_valid = 1'b1;
            in_data  = d[W-1:0];
            in_shamt = sh[W-1:0];
            in_op    = op;
            in_tag   = tag;
            acc = 1'b0;
            n   = 0;
            cs  = 0;
            while (!acc && n < 200) begin
                @(negedge clk);
                acc = in_ready;
                cs  = cyc;
                @(posedge clk);
                n++;
            end
            if (acc) begin
                e.data = model(W, d, sh, op);
                e.tag  = tag;
                e.lat  = lat_mode;
                e.cyc  = cs;
                q.push_back(e);
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL cfg%0d accept_timeout: in_ready low for %0d cycles, want 1", c, n);
            end
            #1 in_valid = 1'b0;
        endtask

        task automatic drain(input string name);
            int n;
            n = 0;
            while (q.size() != 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            check(c, name, 64'(q.size()), 64'd0);
            @(posedge clk);
            #1;
        endtask

        // Monitor: every presented output must match the head of the scoreboard.
        always @(negedge clk) begin
            if (rst) begin
                check(c, "in_ready_in_reset", 64'(in_ready), 64'd0);
            end else begin
                check(c, "in_ready", 64'(in_ready), 64'((q.size() < LAT) || out_ready));
                if (out_valid) begin
                    if (q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL cfg%0d unexpected_output: got tag %0d data 0x%0h, want none",
                                 c, out_tag, out_data);
                    end else begin
                        check(c, "out_data", 64'(out_data), q[0].data);
                        check(c, "out_tag", 64'(out_tag), 64'(q[0].tag));
                        if (out_ready) begin
                            if (q[0].lat) begin
                                check(c, "latency", 64'(cyc - q[0].cyc), 64'(LAT));
                            end
                            void'(q.pop_front());
                        end
                    end
                end
            end
        end

        initial begin
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check(c, "out_valid_after_reset", 64'(out_valid), 64'd0);
            check(c, "in_ready_after_reset", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;

            lat_mode = 1'b1;
            for (int i = 0; i < 9; i++) begin
                send(dir_d[i], dir_s[i], dir_o[i], dir_t[i]);
                drain("directed_drain");
            end

            for (int i = 0; i < 8; i++) begin
                send(rnd64(), rnd64(), 2'($urandom_range(3)), 5'(i));
            end
            drain("stream_drain");

            lat_mode  = 1'b0;
            out_ready = 1'b0;
            fork
                for (int i = 0; i < LAT + 3; i++) begin
                    send(rnd64(), rnd64(), 2'($urandom_range(3)), 5'(10 + i));
                end
                begin
                    repeat (LAT + 5) @(posedge clk);
                    #1 out_ready = 1'b1;
                end
            join
            drain("backpressure_drain");

            lat_mode = 1'b1;
            send(rnd64(), rnd64(), 2'($urandom_range(3)), 5'd20);
            send(rnd64(), rnd64(), 2'($urandom_range(3)), 5'd21);
            rst = 1'b1;
            q.delete();
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check(c, "out_valid_after_flush", 64'(out_valid), 64'd0);
            repeat (LAT + 2) @(posedge clk);
            #1;
            send(rnd64(), rnd64(), 2'($urandom_range(3)), 5'd22);
            drain("post_reset_drain");

            lat_mode = 1'b0;
            fork
                begin
                    for (int i = 0; i < NVEC; i++) begin
                        if ($urandom_range(3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        send(rnd64(), rnd64(), 2'($urandom_range(3)), 5'($urandom));
                    end
                    stop = 1'b1;
                end
                begin
                    while (!stop) begin
                        @(posedge clk);
                        #1 out_ready = ($urandom_range(3) != 0);
                    end
                end
            join
            out_ready = 1'b1;
            drain("random_drain");
            n_done++;
        end
    end

    initial begin
        fork
            wait (n_done == 3);
            begin
                #600_000;
                miscompares++;
                $display("FAIL watchdog: got %0d configurations finished, want 3", n_done);
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Parametrised, pipelined logarithmic shifter for the execute stage.
- Supports SLL, SRL, SRA and ROR at any power-of-two width.
- Register boundaries are selectable between mux levels.
- Uses a valid/ready handshake so the execute pipeline can stall it; a tag (e.g. rd index) rides alongside each operand.

Parameters:
- WIDTH, 32, operand width in bits; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.
- REG_AFTER, 5'b00100, SHW-bit mask; bit k=1 inserts a register after the 2^k mux level.
- TAG_W, 5, width of the sideband tag carried with each operation.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op valid.
- in_ready  output  1  unit can accept this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  WIDTH  shift amount; only [SHW-1:0] used.
- in_op  input  2  shift_op_e: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  input  TAG_W  sideband, returned unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Mux levels: k = 0..SHW-1 in ascending order. Level k shifts by 2^k when shamt[k]=1, else passes through.
- Fill bits per level:
  - SLL: zeros on the right.
  - SRL: zeros on the left.
  - SRA: copies of the original operand MSB, carried down the pipe; never the intermediate MSB.
  - ROR: bits shifted out on the right re-enter on the left.
- Only the low SHW bits of shamt are used; upper bits are ignored. Shamt 0 returns in_data unchanged for all ops.
- Pipeline register slots: one after each level k with REG_AFTER[k]=1, plus an always-present output register.
  - LATENCY = 1 + popcount(REG_AFTER); default is 2 cycles.
- Each register slot holds {valid, data, remaining shamt bits, op, sign, tag}.
- Slot advance rule: slot i loads from slot i-1 (or the input) when slot i is empty or slot i advances this cycle. Last slot advances when out_ready=1.
- in_ready = first slot empty OR first slot advancing.
  - Combinational from out_ready through the chain; full throughput of 1 op/cycle with no bubbles.
- Holding: when out_valid=1 and out_ready=0, out_data, out_tag and out_valid stay stable, and upstream slots fill then hold.
- in_valid=1 while in_ready=0: the input is not captured; the source must hold it.
- Reset: all slot valids clear in the cycle rst is sampled high. Data and tag registers are not reset.
  - During reset: out_valid=0, in_ready=0. After reset: in_ready=1 when empty.
  - Reset mid-operation discards all in-flight ops; nothing is emitted afterwards for them.
- Simultaneous accept and emit in one cycle with a full pipe: both occur and the occupancy count is unchanged.

Decomposition:
- Package shift_pkg:
  - shift_op_e enum (SLL, SRL, SRA, ROR).
  - Function popcount for the LATENCY localparam.
- Sub-module shift_level (parameters WIDTH, DIST):
  - Purely combinational single mux level.
  - Inputs: data, sel bit, op, sign.
  - Output: shifted data.
  - Instantiated SHW times in a generate loop; the pipeline registers live in shift_unit_pipe.

Test Plan:
- Default params, out_ready=1: SRA 0x8000_0000 by 4, tag 3 -> after 2 cycles 0xF800_0000, tag 3, out_valid for 1 cycle.
- SLL 0x0000_0001 by 31 -> 0x8000_0000; SRL 0xF000_0000 by 28 -> 0x0000_000F; ROR 0x0000_0001 by 1 -> 0x8000_0000; shamt 0x25 (upper bits set) SRL 0xFFFF_FFFF -> 0x07FF_FFFF.
- Back-to-back stream of 8 ops, out_ready=1: one result per cycle, in order, tags 0..7 sequential, in_ready never drops.
- Backpressure: fill the pipe, hold out_ready=0 for 5 cycles -> out_data/out_tag stable, in_ready=0 once 2 slots are full. Release -> results drain in order with no loss or duplication.
- Reset asserted with 2 ops in flight -> next cycle out_valid=0. Those tags never appear; a fresh op after reset emerges after 2 cycles.
- Sweep WIDTH=8 with REG_AFTER=0 and WIDTH=64 with REG_AFTER=all-ones -> latency 1 and 7 respectively. Random ops match the reference model over 10k vectors.
